// File: rtl/seg7_capture.sv
// Capture side of a multiplexed active-low 7-segment bus: waits for each digit's
// pattern to settle, decodes it back to a hex nibble and presents NDIG-digit frames.
module seg7_capture #(
  parameter int NDIG          = 4,
  parameter int STABLE_CYCLES = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [6:0]          segs,
  input  logic [NDIG-1:0]     an,
  output logic [4*NDIG-1:0]   value,
  output logic                valid,
  input  logic                ready,
  output logic [NDIG-1:0]     err,
  output logic                overrun
);

  typedef enum logic {
    EMPTY,
    FULL
  } out_state_e;

  localparam int SW = 7 + NDIG;
  localparam logic [7:0] ACCEPT_CNT = 8'(STABLE_CYCLES - 1);

  // Returns {undecodable, nibble}; segment order is gfedcba.
  function automatic logic [4:0] seg_decode(input logic [6:0] p);
    logic [4:0] r;
    case (p)
      7'b1000000: r = 5'h00;
      7'b1111001: r = 5'h01;
      7'b0100100: r = 5'h02;
      7'b0110000: r = 5'h03;
      7'b0011001: r = 5'h04;
      7'b0010010: r = 5'h05;
      7'b0000010: r = 5'h06;
      7'b1111000: r = 5'h07;
      7'b0000000: r = 5'h08;
      7'b0010000: r = 5'h09;
      7'b0001000: r = 5'h0A;
      7'b0000011: r = 5'h0B;
      7'b1000110: r = 5'h0C;
      7'b0100001: r = 5'h0D;
      7'b0000110: r = 5'h0E;
      7'b0001110: r = 5'h0F;
      default:    r = 5'h10;
    endcase
    return r;
  endfunction

  logic [SW-1:0]     s_cur_q, s_cur_d;
  logic [SW-1:0]     s_prev_q, s_prev_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [NDIG-1:0]   mask_q, mask_d;
  logic [NDIG-1:0]   err_stage_q, err_stage_d;
  logic [4*NDIG-1:0] nib_stage_q, nib_stage_d;
  logic [4*NDIG-1:0] value_q, value_d;
  logic [NDIG-1:0]   err_q, err_d;
  logic              overrun_q, overrun_d;
  out_state_e        state_q, state_d;

  logic [NDIG-1:0]   sel;
  logic              one_sel;
  logic              accept;
  logic              transfer;
  logic [4:0]        dec;

  // Sampling and stability counting
  always_comb begin
    s_cur_d  = {segs, an};
    s_prev_d = s_cur_q;
    cnt_d    = '0;
    if (s_cur_q == s_prev_q) begin
      cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
    end
  end

  // The event keys on the value cnt is about to take, so staging is written on
  // the same edge at which cnt reaches STABLE_CYCLES-1; saturation keeps it one-shot.
  always_comb begin
    sel      = ~s_cur_q[NDIG-1:0];
    one_sel  = (sel != '0) && ((sel & (sel - NDIG'(1))) == '0);
    accept   = (cnt_d == ACCEPT_CNT) && one_sel;
    transfer = &mask_q;
    dec      = seg_decode(s_cur_q[SW-1:NDIG]);
  end

  // Frame staging; an accept in the transfer cycle starts the next frame
  always_comb begin
    mask_d      = transfer ? '0 : mask_q;
    err_stage_d = transfer ? '0 : err_stage_q;
    nib_stage_d = nib_stage_q;
    if (accept) begin
      for (int unsigned i = 0; i < NDIG; i++) begin
        if (sel[i]) begin
          mask_d[i]           = 1'b1;
          err_stage_d[i]      = dec[4];
          nib_stage_d[4*i+:4] = dec[3:0];
        end
      end
    end
  end

  // Output handshake FSM
  always_comb begin
    state_d   = state_q;
    value_d   = value_q;
    err_d     = err_q;
    overrun_d = overrun_q;
    if (transfer) begin
      value_d = nib_stage_q;
      err_d   = err_stage_q;
    end
    case (state_q)
      EMPTY: begin
        if (transfer) state_d = FULL;
      end
      FULL: begin
        if (transfer) begin
          if (!ready) overrun_d = 1'b1;
        end else if (ready) begin
          state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s_cur_q     <= '0;
      s_prev_q    <= '0;
      cnt_q       <= '0;
      mask_q      <= '0;
      err_stage_q <= '0;
      nib_stage_q <= '0;
      value_q     <= '0;
      err_q       <= '0;
      overrun_q   <= 1'b0;
      state_q     <= EMPTY;
    end else begin
      s_cur_q     <= s_cur_d;
      s_prev_q    <= s_prev_d;
      cnt_q       <= cnt_d;
      mask_q      <= mask_d;
      err_stage_q <= err_stage_d;
      nib_stage_q <= nib_stage_d;
      value_q     <= value_d;
      err_q       <= err_d;
      overrun_q   <= overrun_d;
      state_q     <= state_d;
    end
  end

  assign value   = value_q;
  assign err     = err_q;
  assign overrun = overrun_q;
  assign valid   = (state_q == FULL);

endmodule

// File: tb/tb_seg7_capture.sv
// Directed bench for seg7_capture (NDIG=4, STABLE_CYCLES=8).
module tb_seg7_capture;

  localparam logic [6:0] P0 = 7'b1000000, P1 = 7'b1111001, P2 = 7'b0100100, P3 = 7'b0110000;
  localparam logic [6:0] P4 = 7'b0011001, P5 = 7'b0010010, P6 = 7'b0000010, P7 = 7'b1111000;
  localparam logic [6:0] P8 = 7'b0000000, P9 = 7'b0010000, PA = 7'b0001000, PB = 7'b0000011;
  localparam logic [6:0] PC = 7'b1000110, PD = 7'b0100001, PE = 7'b0000110, PF = 7'b0001110;
  localparam logic [6:0] DASH = 7'b0111111, BLANK = 7'b1111111;
  localparam logic [3:0] AN0 = 4'b1110, AN1 = 4'b1101, AN2 = 4'b1011, AN3 = 4'b0111;

  logic        clk;
  logic        reset;
  logic [6:0]  segs;
  logic [3:0]  an;
  logic [15:0] value;
  logic        valid;
  logic        ready;
  logic [3:0]  err;
  logic        overrun;

  int checks = 0;
  int failures = 0;
  int valid_cycles = 0;
  int base;

  seg7_capture #(
    .NDIG          (4),
    .STABLE_CYCLES (8)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .segs    (segs),
    .an      (an),
    .value   (value),
    .valid   (valid),
    .ready   (ready),
    .err     (err),
    .overrun (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (valid) valid_cycles <= valid_cycles + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic hold(input logic [6:0] s, input logic [3:0] a, input int n);
    segs = s;
    an   = a;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    segs  = BLANK;
    an    = 4'b1111;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    segs  = BLANK;
    an    = 4'b1111;
    ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_value", 32'(value), 32'h0);
    check("rst_valid", 32'(valid), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    check("rst_overrun", 32'(overrun), 32'h0);
    reset = 1'b1;

    // Basic frame with exact presentation latency
    hold(P0, AN0, 12);
    hold(P5, AN1, 12);
    hold(PA, AN2, 12);
    base = valid_cycles;
    segs = PF;
    an   = AN3;
    repeat (9) @(posedge clk);
    #1;
    check("t1_valid_before", 32'(valid), 32'h0);
    @(posedge clk);
    #1;
    check("t1_valid_at", 32'(valid), 32'h1);
    check("t1_value", 32'(value), 32'hFA50);
    check("t1_err", 32'(err), 32'h0);
    @(posedge clk);
    #1;
    check("t1_valid_after", 32'(valid), 32'h0);
    hold(PF, AN3, 4);
    check("t1_pulse_len", 32'(valid_cycles - base), 32'h1);
    check("t1_overrun", 32'(overrun), 32'h0);
    check("t1_value_kept", 32'(value), 32'hFA50);

    // Short digit blocks the frame until the next full pass
    do_reset();
    base = valid_cycles;
    hold(P1, AN0, 12);
    hold(P2, AN1, 12);
    hold(P3, AN2, 6);
    hold(P4, AN3, 12);
    check("t2_no_frame", 32'(valid_cycles - base), 32'h0);
    hold(P1, AN0, 12);
    hold(P2, AN1, 12);
    hold(P3, AN2, 12);
    hold(P4, AN3, 12);
    check("t2_one_frame", 32'(valid_cycles - base), 32'h1);
    check("t2_value", 32'(value), 32'h4321);
    check("t2_err", 32'(err), 32'h0);

    // Undecodable dash on digit 1
    do_reset();
    hold(P1, AN0, 12);
    hold(DASH, AN1, 12);
    hold(P1, AN2, 12);
    hold(P1, AN3, 12);
    check("t3_value", 32'(value), 32'h1101);
    check("t3_err", 32'(err), 32'h2);
    check("t3_overrun", 32'(overrun), 32'h0);

    // Back-pressure: overwrite sets overrun
    do_reset();
    ready = 1'b0;
    hold(P4, AN0, 12);
    hold(P3, AN1, 12);
    hold(P2, AN2, 12);
    hold(P1, AN3, 12);
    check("t4_valid1", 32'(valid), 32'h1);
    check("t4_value1", 32'(value), 32'h1234);
    check("t4_overrun1", 32'(overrun), 32'h0);
    hold(P8, AN0, 12);
    hold(P7, AN1, 12);
    hold(P6, AN2, 12);
    check("t4_value_stable", 32'(value), 32'h1234);
    hold(P5, AN3, 12);
    check("t4_value2", 32'(value), 32'h5678);
    check("t4_valid2", 32'(valid), 32'h1);
    check("t4_overrun2", 32'(overrun), 32'h1);
    ready = 1'b1;
    @(posedge clk);
    #1;
    check("t4_valid_drop", 32'(valid), 32'h0);
    check("t4_value_kept", 32'(value), 32'h5678);
    check("t4_overrun_sticky", 32'(overrun), 32'h1);

    // Blanking and multi-anode gaps are ignored
    do_reset();
    ready = 1'b0;
    hold(P9, AN0, 12);
    hold(P8, AN1, 12);
    hold(BLANK, 4'b1111, 20);
    hold(DASH, 4'b1100, 20);
    hold(PB, AN2, 12);
    check("t5_no_early_frame", 32'(valid), 32'h0);
    hold(PC, AN3, 12);
    check("t5_valid", 32'(valid), 32'h1);
    check("t5_value", 32'(value), 32'hCB89);
    check("t5_err", 32'(err), 32'h0);

    // Asynchronous reset mid-frame discards the partial mask
    hold(PE, AN0, 12);
    hold(PD, AN1, 12);
    hold(PC, AN2, 12);
    check("t6_valid_pre", 32'(valid), 32'h1);
    #3;
    reset = 1'b0;
    #1;
    check("t6_async_value", 32'(value), 32'h0);
    check("t6_async_valid", 32'(valid), 32'h0);
    segs = BLANK;
    an   = 4'b1111;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    ready = 1'b1;
    base  = valid_cycles;
    hold(P9, AN3, 12);
    check("t6_partial_discarded", 32'(valid_cycles - base), 32'h0);
    hold(P6, AN0, 12);
    hold(P7, AN1, 12);
    hold(P8, AN2, 12);
    check("t6_one_frame", 32'(valid_cycles - base), 32'h1);
    check("t6_value", 32'(value), 32'h9876);
    check("t6_err", 32'(err), 32'h0);
    check("t6_overrun", 32'(overrun), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
